// File: rtl/lsu_arb_if.sv
// Bundle of host, fetch, data and RAM signals around the load/store arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface lsu_arb_if #(
    parameter int AW = 9,
    parameter int RW = 4
);
    logic            working;
    logic            host_we;
    logic [AW-1:0]   host_addr;
    logic [31:0]     host_wdata;

    logic            if_req;
    logic [AW-1:0]   if_addr;
    logic            if_ready;
    logic            if_valid;
    logic [31:0]     if_instr;

    logic            mem_req;
    logic            mem_we;
    logic [1:0]      mem_size;
    logic            mem_signed;
    logic [AW+1:0]   mem_addr;
    logic [31:0]     mem_wdata;
    logic [RW-1:0]   mem_dst;
    logic            mem_ready;
    logic            mem_valid;
    logic [31:0]     mem_rdata;
    logic [RW-1:0]   mem_dst_out;
    logic            mem_err;

    logic [AW-1:0]   ram_addr;
    logic            ram_wen;
    logic [3:0]      ram_ben;
    logic [31:0]     ram_wdata;
    logic            ram_ren;
    logic [31:0]     ram_rdata;

    modport slave (
        input  working, host_we, host_addr, host_wdata,
        input  if_req, if_addr,
        output if_ready, if_valid, if_instr,
        input  mem_req, mem_we, mem_size, mem_signed, mem_addr, mem_wdata, mem_dst,
        output mem_ready, mem_valid, mem_rdata, mem_dst_out, mem_err,
        output ram_addr, ram_wen, ram_ben, ram_wdata, ram_ren,
        input  ram_rdata
    );

    modport master (
        output working, host_we, host_addr, host_wdata,
        output if_req, if_addr,
        input  if_ready, if_valid, if_instr,
        output mem_req, mem_we, mem_size, mem_signed, mem_addr, mem_wdata, mem_dst,
        input  mem_ready, mem_valid, mem_rdata, mem_dst_out, mem_err,
        input  ram_addr, ram_wen, ram_ben, ram_wdata, ram_ren,
        output ram_rdata
    );
endinterface

// File: rtl/lsu_arb.sv
// Arbitrates a single-port synchronous RAM between fetch, data load/store and
// host loading; handles byte/half/word lanes, extension and misalignment.
module lsu_arb #(
    parameter int AW     = 9,
    parameter int RD_LAT = 1,
    parameter int RW     = 4
) (
    input logic       clock,
    input logic       reset,
    lsu_arb_if.slave  bus
);
    // state   | meaning
    // IDLE    | ready for a request (processor) or passing host writes (host mode)
    // RD_WAIT | RAM read issued, counting down read latency
    // RESP    | one-cycle response pulse on the owning channel
    typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_t;

    localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

    state_t         state, state_nx;
    logic [1:0]     cnt;
    logic           lat_fetch;
    logic [1:0]     lat_off;
    logic [1:0]     lat_size;
    logic           lat_sgn;
    logic [RW-1:0]  lat_dst;

    logic [31:0]    if_instr_q;
    logic [31:0]    mem_rdata_q;
    logic [RW-1:0]  mem_dst_q;
    logic           mem_err_q;

    logic           if_ready, mem_ready;
    logic           acc_mem, acc_if, misal;
    logic [AW-1:0]  ram_addr;
    logic           ram_wen, ram_ren;
    logic [3:0]     ram_ben;
    logic [31:0]    ram_wdata;
    logic [31:0]    lane, ext;

    always_comb begin
        misal = ((bus.mem_size == 2'd1) && bus.mem_addr[0]) ||
                (bus.mem_size[1] && (bus.mem_addr[1:0] != 2'b00));
    end

    always_comb begin
        lane = bus.ram_rdata >> {lat_off, 3'b000};
        case (lat_size)
            2'd0:    ext = {{24{lat_sgn & lane[7]}},  lane[7:0]};
            2'd1:    ext = {{16{lat_sgn & lane[15]}}, lane[15:0]};
            default: ext = lane;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        if_ready  = 1'b0;
        mem_ready = 1'b0;
        acc_mem   = 1'b0;
        acc_if    = 1'b0;
        ram_addr  = '0;
        ram_wen   = 1'b0;
        ram_ren   = 1'b0;
        ram_ben   = 4'h0;
        ram_wdata = 32'h0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (!bus.working) begin
                        // host writes only reach the RAM from IDLE
                        ram_wen   = bus.host_we;
                        ram_addr  = bus.host_addr;
                        ram_ben   = 4'hF;
                        ram_wdata = bus.host_wdata;
                    end else if (bus.mem_req) begin
                        mem_ready = 1'b1;
                        acc_mem   = 1'b1;
                        if (misal) begin
                            state_nx = RESP;
                        end else if (bus.mem_we) begin
                            ram_wen  = 1'b1;
                            ram_addr = bus.mem_addr[AW+1:2];
                            case (bus.mem_size)
                                2'd0: begin
                                    ram_ben   = 4'b0001 << bus.mem_addr[1:0];
                                    ram_wdata = {4{bus.mem_wdata[7:0]}};
                                end
                                2'd1: begin
                                    ram_ben   = 4'b0011 << bus.mem_addr[1:0];
                                    ram_wdata = {2{bus.mem_wdata[15:0]}};
                                end
                                default: begin
                                    ram_ben   = 4'hF;
                                    ram_wdata = bus.mem_wdata;
                                end
                            endcase
                            state_nx = RESP;
                        end else begin
                            ram_ren  = 1'b1;
                            ram_addr = bus.mem_addr[AW+1:2];
                            state_nx = RD_WAIT;
                        end
                    end else if (bus.if_req) begin
                        if_ready = 1'b1;
                        acc_if   = 1'b1;
                        ram_ren  = 1'b1;
                        ram_addr = bus.if_addr;
                        state_nx = RD_WAIT;
                    end
                end
                RD_WAIT: if (cnt == 2'd0) state_nx = RESP;
                RESP:    state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt         <= '0;
            lat_fetch   <= 1'b0;
            lat_off     <= 2'b00;
            lat_size    <= 2'b00;
            lat_sgn     <= 1'b0;
            lat_dst     <= '0;
            if_instr_q  <= 32'h0;
            mem_rdata_q <= 32'h0;
            mem_dst_q   <= '0;
            mem_err_q   <= 1'b0;
        end else begin
            if (acc_mem) begin
                cnt       <= CNT_INIT;
                lat_fetch <= 1'b0;
                lat_off   <= bus.mem_addr[1:0];
                lat_size  <= bus.mem_size;
                lat_sgn   <= bus.mem_signed;
                lat_dst   <= bus.mem_dst;
                // stores and misaligned requests respond without read data
                if (misal || bus.mem_we) begin
                    mem_rdata_q <= 32'h0;
                    mem_err_q   <= misal;
                    mem_dst_q   <= bus.mem_dst;
                end
            end else if (acc_if) begin
                cnt       <= CNT_INIT;
                lat_fetch <= 1'b1;
            end
            if (state == RD_WAIT) begin
                if (cnt != 2'd0) begin
                    cnt <= cnt - 2'd1;
                end else if (lat_fetch) begin
                    if_instr_q <= bus.ram_rdata;
                end else begin
                    mem_rdata_q <= ext;
                    mem_err_q   <= 1'b0;
                    mem_dst_q   <= lat_dst;
                end
            end
        end
    end

    assign bus.if_ready    = if_ready;
    assign bus.if_valid    = (state == RESP) && lat_fetch;
    assign bus.if_instr    = if_instr_q;
    assign bus.mem_ready   = mem_ready;
    assign bus.mem_valid   = (state == RESP) && !lat_fetch;
    assign bus.mem_rdata   = mem_rdata_q;
    assign bus.mem_dst_out = mem_dst_q;
    assign bus.mem_err     = mem_err_q;
    assign bus.ram_addr    = ram_addr;
    assign bus.ram_wen     = ram_wen;
    assign bus.ram_ren     = ram_ren;
    assign bus.ram_ben     = ram_ben;
    assign bus.ram_wdata   = ram_wdata;
endmodule

// File: tb/tb_lsu_arb.sv
// Directed bench for lsu_arb: stimulus pushes expected responses into a
// scoreboard queue, a negedge monitor pops and compares them.
module tb_lsu_arb;
    localparam int AW  = 9;
    localparam int RW  = 4;
    localparam int LAT = 3;

    typedef struct {
        logic        fetch;
        logic [31:0] data;
        logic [3:0]  dst;
        logic        err;
        int          cyc;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t mon_e;

    lsu_arb_if #(.AW(AW), .RW(RW)) bus ();

    lsu_arb #(.AW(AW), .RD_LAT(LAT), .RW(RW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // RAM model with LAT-cycle read pipeline
    logic [31:0] ram  [0:(1<<AW)-1];
    logic [31:0] pipe [0:LAT-1];
    always @(posedge clock) begin
        if (bus.ram_wen)
            for (int b = 0; b < 4; b++)
                if (bus.ram_ben[b]) ram[bus.ram_addr][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
        if (bus.ram_ren) pipe[0] <= ram[bus.ram_addr];
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign bus.ram_rdata = pipe[LAT-1];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clock) begin
        if (bus.if_valid || bus.mem_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp if_valid=%b mem_valid=%b expected none (cycle %0d)",
                         bus.if_valid, bus.mem_valid, cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("resp_is_fetch", {31'b0, bus.if_valid}, {31'b0, mon_e.fetch});
                chk("resp_one_channel", {31'b0, bus.if_valid & bus.mem_valid}, 32'h0);
                if (mon_e.fetch) begin
                    chk("if_instr", bus.if_instr, mon_e.data);
                end else begin
                    chk("mem_rdata", bus.mem_rdata, mon_e.data);
                    chk("mem_dst_out", {28'b0, bus.mem_dst_out}, {28'b0, mon_e.dst});
                    chk("mem_err", {31'b0, bus.mem_err}, {31'b0, mon_e.err});
                end
                chk("resp_cycle", cyc, mon_e.cyc);
            end
        end
    end

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clock);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout pending=%0d expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_if_ready"},  {31'b0, bus.if_ready}, 32'h0);
        chk({nm, "_if_valid"},  {31'b0, bus.if_valid}, 32'h0);
        chk({nm, "_if_instr"},  bus.if_instr, 32'h0);
        chk({nm, "_mem_ready"}, {31'b0, bus.mem_ready}, 32'h0);
        chk({nm, "_mem_valid"}, {31'b0, bus.mem_valid}, 32'h0);
        chk({nm, "_mem_rdata"}, bus.mem_rdata, 32'h0);
        chk({nm, "_mem_dst"},   {28'b0, bus.mem_dst_out}, 32'h0);
        chk({nm, "_mem_err"},   {31'b0, bus.mem_err}, 32'h0);
        chk({nm, "_ram_ctl"},   {25'b0, bus.ram_wen, bus.ram_ren, bus.ram_ben}, 32'h0);
        chk({nm, "_ram_addr"},  {23'b0, bus.ram_addr}, 32'h0);
        chk({nm, "_ram_wdata"}, bus.ram_wdata, 32'h0);
    endtask

    task automatic host_write(input logic [AW-1:0] a, input logic [31:0] d);
        @(posedge clock); #1;
        bus.working = 1'b0; bus.host_we = 1'b1; bus.host_addr = a; bus.host_wdata = d;
        bus.if_req = 1'b1; bus.if_addr = a; bus.mem_req = 1'b1; bus.mem_we = 1'b0;
        @(negedge clock);
        chk("host_ram_wen",   {31'b0, bus.ram_wen}, 32'h1);
        chk("host_ram_addr",  {23'b0, bus.ram_addr}, {23'b0, a});
        chk("host_ram_ben",   {28'b0, bus.ram_ben}, 32'hF);
        chk("host_ram_wdata", bus.ram_wdata, d);
        chk("host_readies",   {30'b0, bus.if_ready, bus.mem_ready}, 32'h0);
        @(posedge clock); #1;
        bus.host_we = 1'b0; bus.if_req = 1'b0; bus.mem_req = 1'b0;
    endtask

    task automatic mem_issue(input logic we, input logic [1:0] size, input logic sgn,
                             input logic [AW+1:0] addr, input logic [31:0] wdata,
                             input logic [3:0] dst, input logic [31:0] exp_data,
                             input logic exp_err, input logic [3:0] exp_ben,
                             output int waited);
        exp_t e;
        int n = 0;
        @(posedge clock); #1;
        reset = 1'b0; bus.working = 1'b1;
        bus.mem_req = 1'b1; bus.mem_we = we; bus.mem_size = size; bus.mem_signed = sgn;
        bus.mem_addr = addr; bus.mem_wdata = wdata; bus.mem_dst = dst;
        @(negedge clock);
        while (!bus.mem_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        waited = n;
        if (!bus.mem_ready) begin
            checks++;
            errors++;
            $display("FAIL mem_accept_timeout mem_ready=0 expected 1");
        end else begin
            chk("acc_ram_wen", {31'b0, bus.ram_wen}, {31'b0, we & ~exp_err});
            chk("acc_ram_ren", {31'b0, bus.ram_ren}, {31'b0, ~we & ~exp_err});
            if (!exp_err) chk("acc_ram_addr", {23'b0, bus.ram_addr}, {23'b0, addr[AW+1:2]});
            if (we && !exp_err) chk("acc_ram_ben", {28'b0, bus.ram_ben}, {28'b0, exp_ben});
            e.fetch = 1'b0; e.data = exp_data; e.dst = dst; e.err = exp_err;
            e.cyc = cyc + ((we || exp_err) ? 1 : LAT + 1);
            sb.push_back(e);
        end
    endtask

    task automatic mem_op(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [AW+1:0] addr, input logic [31:0] wdata,
                          input logic [3:0] dst, input logic [31:0] exp_data,
                          input logic exp_err, input logic [3:0] exp_ben);
        int w;
        mem_issue(we, size, sgn, addr, wdata, dst, exp_data, exp_err, exp_ben, w);
        @(posedge clock); #1;
        bus.mem_req = 1'b0;
        drain();
    endtask

    task automatic if_op(input logic [AW-1:0] a, input logic [31:0] exp_instr);
        exp_t e;
        int n = 0;
        @(posedge clock); #1;
        bus.working = 1'b1; bus.if_req = 1'b1; bus.if_addr = a;
        @(negedge clock);
        while (!bus.if_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("if_ready_first_cycle", n, 0);
        e.fetch = 1'b1; e.data = exp_instr; e.dst = '0; e.err = 1'b0; e.cyc = cyc + LAT + 1;
        sb.push_back(e);
        @(posedge clock); #1;
        bus.if_req = 1'b0;
        drain();
    endtask

    initial begin
        exp_t e;
        int n, acc, w;
        reset = 1'b1;
        bus.working = 1'b0; bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.mem_req = 1'b0; bus.mem_we = 1'b0; bus.mem_size = 2'd0; bus.mem_signed = 1'b0;
        bus.mem_addr = '0; bus.mem_wdata = '0; bus.mem_dst = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_zero("reset");
        @(posedge clock); #1;
        reset = 1'b0;

        host_write(9'd5, 32'h12345678);
        host_write(9'd4, 32'h0);
        host_write(9'd8, 32'h0);
        host_write(9'd7, 32'hCAFEF00D);

        if_op(9'd5, 32'h12345678);
        repeat (3) @(negedge clock);
        chk("if_instr_hold", bus.if_instr, 32'h12345678);

        // we, size, sgn, addr, wdata, dst, exp_data, exp_err, exp_ben
        mem_op(1'b1, 2'd0, 1'b0, 11'h011, 32'h00000080, 4'd1, 32'h0,        1'b0, 4'b0010);
        mem_op(1'b0, 2'd0, 1'b1, 11'h011, 32'h0,        4'd3, 32'hFFFFFF80, 1'b0, 4'h0);
        mem_op(1'b0, 2'd0, 1'b0, 11'h011, 32'h0,        4'd5, 32'h00000080, 1'b0, 4'h0);
        mem_op(1'b0, 2'd2, 1'b0, 11'h010, 32'h0,        4'd6, 32'h00008000, 1'b0, 4'h0);
        mem_op(1'b1, 2'd1, 1'b0, 11'h022, 32'h0000BEEF, 4'd7, 32'h0,        1'b0, 4'b1100);
        mem_op(1'b0, 2'd1, 1'b1, 11'h022, 32'h0,        4'd9, 32'hFFFFBEEF, 1'b0, 4'h0);
        mem_op(1'b0, 2'd1, 1'b0, 11'h022, 32'h0,        4'd10, 32'h0000BEEF, 1'b0, 4'h0);
        mem_op(1'b0, 2'd0, 1'b1, 11'h023, 32'h0,        4'd11, 32'hFFFFFFBE, 1'b0, 4'h0);
        mem_op(1'b0, 2'd3, 1'b0, 11'h020, 32'h0,        4'd12, 32'hBEEF0000, 1'b0, 4'h0);
        repeat (2) @(negedge clock);
        chk("mem_rdata_hold", bus.mem_rdata, 32'hBEEF0000);
        chk("mem_dst_hold", {28'b0, bus.mem_dst_out}, 32'd12);

        // misaligned: word load and half store both error without touching RAM
        mem_op(1'b0, 2'd2, 1'b0, 11'h013, 32'h0,        4'd13, 32'h0,        1'b1, 4'h0);
        mem_op(1'b1, 2'd1, 1'b0, 11'h021, 32'h00001234, 4'd14, 32'h0,        1'b1, 4'h0);
        mem_op(1'b0, 2'd2, 1'b0, 11'h020, 32'h0,        4'd15, 32'hBEEF0000, 1'b0, 4'h0);

        // data request wins over a simultaneous fetch
        @(posedge clock); #1;
        bus.working = 1'b1; bus.if_req = 1'b1; bus.if_addr = 9'd7;
        bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_size = 2'd2; bus.mem_signed = 1'b0;
        bus.mem_addr = 11'h010; bus.mem_dst = 4'd2;
        @(negedge clock);
        chk("arb_mem_ready", {31'b0, bus.mem_ready}, 32'h1);
        chk("arb_if_ready", {31'b0, bus.if_ready}, 32'h0);
        acc = cyc;
        e.fetch = 1'b0; e.data = 32'h00008000; e.dst = 4'd2; e.err = 1'b0; e.cyc = acc + LAT + 1;
        sb.push_back(e);
        @(posedge clock); #1;
        bus.mem_req = 1'b0;
        n = 0;
        @(negedge clock);
        while (!bus.if_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("arb_if_accept_cycle", cyc, acc + LAT + 2);
        e.fetch = 1'b1; e.data = 32'hCAFEF00D; e.dst = '0; e.err = 1'b0; e.cyc = cyc + LAT + 1;
        sb.push_back(e);
        @(posedge clock); #1;
        bus.if_req = 1'b0;
        drain();

        // working drops while a load is in flight
        mem_issue(1'b0, 2'd2, 1'b0, 11'h010, 32'h0, 4'd8, 32'h00008000, 1'b0, 4'h0, w);
        @(posedge clock); #1;
        bus.working = 1'b0; bus.host_we = 1'b1; bus.host_addr = 9'd20; bus.host_wdata = 32'hA5A5A5A5;
        @(negedge clock);
        chk("wfall_no_host_write", {31'b0, bus.ram_wen}, 32'h0);
        chk("wfall_mem_ready", {31'b0, bus.mem_ready}, 32'h0);
        drain();
        repeat (2) @(negedge clock);
        chk("wfall_mem_ready_idle", {31'b0, bus.mem_ready}, 32'h0);
        @(posedge clock); #1;
        bus.host_we = 1'b0; bus.mem_req = 1'b0;
        mem_op(1'b0, 2'd2, 1'b0, 11'h050, 32'h0, 4'd4, 32'hA5A5A5A5, 1'b0, 4'h0);

        // reset during RD_WAIT drops the load
        mem_issue(1'b0, 2'd2, 1'b0, 11'h014, 32'h0, 4'd6, 32'h0, 1'b0, 4'h0, w);
        sb.delete();
        @(posedge clock); #1;
        bus.mem_req = 1'b0;
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check_zero("midreset");
        repeat (4) @(negedge clock);
        chk("midreset_hold_rdata", bus.mem_rdata, 32'h0);
        mem_issue(1'b0, 2'd2, 1'b0, 11'h020, 32'h0, 4'd3, 32'hBEEF0000, 1'b0, 4'h0, w);
        chk("ready_after_reset", w, 0);
        @(posedge clock); #1;
        bus.mem_req = 1'b0;
        drain();
        repeat (6) @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/lsu_arb.md
Name: lsu_arb

Overview:
- Parametrised load/store unit that arbitrates one single-port synchronous RAM between instruction fetch, data load/store, and host program loading.
- Adds byte, half-word and word access with sign or zero extension.
- Adds misalignment detection, configurable RAM read latency, and valid/ready handshakes on both processor-side channels.
- Sits between the processor's fetch and memory stages and the unified instruction/data RAM.

Parameters:
- AW, 9, RAM word-address width; byte address width is AW+2.
- RD_LAT, 1, RAM read latency in cycles, legal range 1..4.
- RW, 4, register-index width carried with loads.

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high reset
- working  in  1  1 = processor running; 0 = host load mode
- host_we  in  1  host word write strobe, honoured only when working=0
- host_addr  in  AW  host word address
- host_wdata  in  32  host write data
- if_req  in  1  fetch request
- if_addr  in  AW  fetch word address
- if_ready  out  1  fetch request accepted this cycle
- if_valid  out  1  one-cycle fetch response pulse
- if_instr  out  32  fetched instruction; holds its value between responses
- mem_req  in  1  data request
- mem_we  in  1  1 = store, 0 = load
- mem_size  in  2  0 = byte, 1 = half-word, 2 = word; 3 is treated as word
- mem_signed  in  1  sign-extend loads
- mem_addr  in  AW+2  byte address
- mem_wdata  in  32  store data, right-aligned
- mem_dst  in  RW  load destination register
- mem_ready  out  1  data request accepted this cycle
- mem_valid  out  1  one-cycle data response pulse
- mem_rdata  out  32  extended load data
- mem_dst_out  out  RW  destination register returned with the response
- mem_err  out  1  misaligned access flag, valid with mem_valid
- ram_addr  out  AW  RAM word address
- ram_wen  out  1  RAM write enable
- ram_ben  out  4  RAM byte enables
- ram_wdata  out  32  RAM write data, lane-shifted
- ram_ren  out  1  RAM read enable
- ram_rdata  in  32  RAM read data, RD_LAT cycles after ram_ren

Behaviour:
- Reset (synchronous):
  - FSM goes to IDLE.
  - All outputs go to 0, including if_instr, mem_rdata, mem_dst_out and mem_err.
  - Any in-flight response is dropped and never issued.
- FSM states: IDLE, RD_WAIT, RESP.
- Only one request is outstanding at a time.
- Host mode (working=0):
  - if_ready and mem_ready are 0.
  - ram_wen = host_we, ram_addr = host_addr, ram_ben = 4'hF, ram_wdata = host_wdata.
  - Processor-side requests are ignored.
- Readiness: if_ready and mem_ready may be 1 only when state = IDLE and working = 1.
- Arbitration: mem_req has priority over if_req. If both are high, only mem_ready is asserted; the fetch waits.
- Store acceptance (IDLE, mem_req=1, mem_we=1, aligned):
  - In the same cycle: ram_wen=1, ram_addr = mem_addr[AW+1:2].
  - ram_ben: byte = 1 << addr[1:0]; half = 2'b11 << addr[1:0]; word = 4'hF.
  - ram_wdata = mem_wdata replicated into the selected lanes.
  - Next state RESP. mem_valid pulses the next cycle with mem_err=0 and mem_rdata=0.
- Load or fetch acceptance:
  - ram_ren=1 with the address driven.
  - Latch the kind (load/fetch), byte offset, size, signed flag and dst.
  - Go to RD_WAIT. A down-counter starts at RD_LAT-1.
  - When the counter reaches 0 and ram_rdata is valid, capture and extract the data, then go to RESP.
- Load extraction:
  - Select the lane by the latched offset.
  - Byte: bits [7:0] extended; half: bits [15:0] extended; word: unchanged.
  - Sign-extend if mem_signed=1, otherwise zero-extend.
- RESP lasts exactly 1 cycle:
  - Pulse mem_valid (with mem_rdata and mem_dst_out) or if_valid (with if_instr).
  - Return to IDLE. A new request can be accepted in the cycle after RESP.
- Latency:
  - Store: valid 1 cycle after acceptance.
  - Load/fetch: valid RD_LAT+1 cycles after acceptance.
- Misalignment: half with addr[0]=1, or word with addr[1:0]≠0.
  - Request is accepted with no RAM access (ram_wen = ram_ren = 0).
  - Go to RESP. mem_valid pulses with mem_err=1 and mem_rdata=0.
- Hold behaviour:
  - if_instr, mem_rdata and mem_dst_out hold their values until the next response of the same channel.
  - mem_err clears on the next mem_valid.
- working falling mid-operation:
  - The in-flight operation completes and responds normally.
  - New requests are not accepted.
  - Host writes take effect only once the FSM is in IDLE.
- Address wrap: word address is mem_addr[AW+1:2]; upper bits do not exist.

Test Plan:
- Host load, then fetch:
  - working=0; host writes 0x12345678 to addr 5.
  - working=1; if_req with if_addr=5.
  - Expect if_ready in the first cycle, if_valid RD_LAT+1 cycles later with if_instr = 0x12345678, and if_instr held afterwards.
- Byte store, signed and unsigned load:
  - Word at byte address 0x10 preset to 0; store byte 0x80 to mem_addr 0x11.
  - Expect ram_ben = 4'b0010.
  - Signed byte load from 0x11 returns 0xFFFFFF80; unsigned load returns 0x00000080.
  - Word load from 0x10 returns 0x00008000.
- Half-word access:
  - Store 0xBEEF to mem_addr 0x22; expect ram_ben = 4'b1100.
  - Signed half load returns 0xFFFFBEEF; mem_dst_out equals the mem_dst given at request time.
- Arbitration:
  - Assert mem_req (load) and if_req together.
  - Expect mem_ready=1, if_ready=0 in the same cycle.
  - The fetch is accepted the cycle after mem_valid and completes with the correct instruction.
- Misalignment:
  - Word load from 0x13 → mem_valid with mem_err=1, mem_rdata=0, no ram_ren/ram_wen.
  - Half store to 0x21 → same error response, RAM contents unchanged.
- Reset mid-load (run with RD_LAT=3):
  - Assert reset during RD_WAIT.
  - Expect no mem_valid ever issued and all outputs 0.
  - mem_ready=1 again in the first cycle after reset is released with working=1.
